gpio_in_conditioner: RTL



---
 rtl/gpio_pkg.sv | 25 ++
 rtl/gpio_debounce_bit.sv | 59 +++++
 rtl/gpio_in_conditioner.sv | 86 ++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO constants: default conditioner geometry and the core's GPIO register map.
// Also holds the per-bit event record and a counter-width helper.
package gpio_pkg;

    localparam int GPIO_WIDTH          = 32;
    localparam int GPIO_TICK_DIV       = 50000;
    localparam int GPIO_STABLE_SAMPLES = 4;

    // Addresses the core decodes for its GPIO read/write ports.
    localparam logic [11:0] GPIO_ADDR_IO0_IN  = 12'hf00;
    localparam logic [11:0] GPIO_ADDR_IO1_IN  = 12'hf01;
    localparam logic [11:0] GPIO_ADDR_IO0_OUT = 12'hf02;
    localparam logic [11:0] GPIO_ADDR_IO1_OUT = 12'hf03;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } gpio_bit_evt_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, sample history on the shared tick,
// unanimous-history level decision and registered rise/fall pulses.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int STABLE_SAMPLES = GPIO_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic sample_tick,
    output logic level,
    output logic rise,
    output logic fall
);

    logic                      sync1_q, sync1_d;
    logic                      sync2_q, sync2_d;
    logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
    gpio_bit_evt_t             evt_q, evt_d;
    logic                      level_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        hist_d  = hist_q;
        level_d = evt_q.level;
        if (sample_tick) begin
            hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q};
            if (&hist_d)
                level_d = 1'b1;
            else if (~|hist_d)
                level_d = 1'b0;
        end
        // Pulses compare against the level being replaced, so they line up with the new level.
        evt_d.level = level_d;
        evt_d.rise  = level_d & ~evt_q.level;
        evt_d.fall  = ~level_d & evt_q.level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            evt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            evt_q   <= evt_d;
        end
    end

    assign level = evt_q.level;
    assign rise  = evt_q.rise;
    assign fall  = evt_q.fall;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: shared debounce prescaler plus WIDTH debounced bits.
// Optional GPIO_EDGE_COUNT_EN adds a 16-bit rising-edge counter on bit 0 with sync clear.
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH          = GPIO_WIDTH,
    parameter int TICK_DIV       = GPIO_TICK_DIV,
    parameter int STABLE_SAMPLES = GPIO_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             sample_tick
`ifdef GPIO_EDGE_COUNT_EN
    ,
    input  logic             edge_count_clr,
    output logic [15:0]      edge_count
`endif
);

    localparam int            CW       = cnt_w(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // The tick is registered from the next count so it reads 0 in reset even when TICK_DIV=1.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick = tick_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            gpio_debounce_bit #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_bit (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw        (raw_in[i]),
                .sample_tick(tick_q),
                .level      (io_out[i]),
                .rise       (rise_pulse[i]),
                .fall       (fall_pulse[i])
            );
        end
    endgenerate

`ifdef GPIO_EDGE_COUNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (edge_count_clr)
            edge_cnt_d = '0;
        else if (rise_pulse[0])
            edge_cnt_d = edge_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_cnt_q <= '0;
        else
            edge_cnt_q <= edge_cnt_d;
    end

    assign edge_count = edge_cnt_q;
`endif

endmodule
